// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the instruction/data SRAM port arbiter.
// Request records carry an owner tag so a response lands in the right rdata register.
package sram_port_arbiter_pkg;

    localparam int ADDR_W_P = 32;
    localparam int DATA_W_P = 32;
    localparam int BE_W_P   = DATA_W_P / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef struct packed {
        logic                owner;
        logic [BE_W_P-1:0]   wen;
        logic [ADDR_W_P-1:0] addr;
        logic [DATA_W_P-1:0] wdata;
    } req_t;

    function automatic logic is_read(input req_t r);
        return r.wen == '0;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_req_buf.sv
// One-entry pending request register with valid flag.
// Latency: loaded entry visible the cycle after load; load has priority over clear.
// Backpressure: none; the owner must only load while the entry is empty.
module sram_req_buf
    import sram_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_vld,
    input  req_t load_dat,
    input  logic clr,
    output logic buf_vld,
    output req_t buf_dat
);

    logic vld_q, vld_d;
    req_t dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clr) begin
            vld_d = 1'b0;
        end
        if (load_vld) begin
            vld_d = 1'b1;
            dat_d = load_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign buf_vld = vld_q;
    assign buf_dat = dat_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Merges instruction and data SRAM ports onto one req/gnt/rvalid memory port, data first.
// Latency: 3 cycles request-to-release with zero-wait memory; +2 when both ports request.
// Backpressure: stallreq holds the core until resp_done; mem payload holds until mem_gnt.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_sram_en,
    input  logic [DATA_W/8-1:0] inst_sram_wen,
    input  logic [ADDR_W-1:0]   inst_sram_addr,
    input  logic [DATA_W-1:0]   inst_sram_wdata,
    output logic [DATA_W-1:0]   inst_sram_rdata,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                stallreq,
    output logic                mem_req,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t              state_q, state_d;
    req_t                cur_q, cur_d;
    logic                mem_req_q, mem_req_d;
    logic                resp_done_q, resp_done_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

    req_t inst_req, data_req;
    logic pend_load, pend_clr, pend_vld;
    req_t pend_dat;

    assign inst_req = '{owner: OWN_INST, wen: inst_sram_wen,
                        addr: inst_sram_addr, wdata: inst_sram_wdata};
    assign data_req = '{owner: OWN_DATA, wen: data_sram_wen,
                        addr: data_sram_addr, wdata: data_sram_wdata};

    sram_req_buf u_pend (
        .clk      (clk),
        .rst      (rst),
        .load_vld (pend_load),
        .load_dat (inst_req),
        .clr      (pend_clr),
        .buf_vld  (pend_vld),
        .buf_dat  (pend_dat)
    );

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        mem_req_d    = mem_req_q;
        resp_done_d  = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        pend_load    = 1'b0;
        pend_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // resp_done marks the cycle the core consumes the result; the
                // en seen now still belongs to the request just finished.
                if (!resp_done_q && (data_sram_en || inst_sram_en)) begin
                    state_d   = ST_REQ;
                    mem_req_d = 1'b1;
                    if (data_sram_en) begin
                        cur_d     = data_req;
                        pend_load = inst_sram_en;
                    end else begin
                        cur_d = inst_req;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    if (is_read(cur_q)) begin
                        if (cur_q.owner == OWN_DATA) begin
                            data_rdata_d = mem_rdata;
                        end else begin
                            inst_rdata_d = mem_rdata;
                        end
                    end
                    if (pend_vld) begin
                        cur_d     = pend_dat;
                        pend_clr  = 1'b1;
                        mem_req_d = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        state_d     = ST_IDLE;
                        resp_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            mem_req_q    <= 1'b0;
            resp_done_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            mem_req_q    <= mem_req_d;
            resp_done_q  <= resp_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign mem_req         = mem_req_q;
    assign mem_wen         = cur_q.wen;
    assign mem_addr        = cur_q.addr;
    assign mem_wdata       = cur_q.wdata;
    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign stallreq        = (inst_sram_en | data_sram_en) & ~resp_done_q;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

- Merges the core's instruction-SRAM and data-SRAM request ports onto one shared memory port with a req/gnt/rvalid handshake.
- Sits directly downstream of the CPU core, between its SRAM-like ports and the single-ported memory/bus adapter.
- Serialises simultaneous fetch and load/store requests, holds read data stable for the core, and stalls the core while any request is outstanding.

## Interface
Parameters
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)

Ports
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- inst_sram_en  in  1  instruction request valid (held by core while stalled)
- inst_sram_wen  in  4  instruction byte write enables (always 0 in practice; forwarded anyway)
- inst_sram_addr  in  32  instruction address
- inst_sram_wdata  in  32  instruction write data
- inst_sram_rdata  out  32  instruction read data, held
- data_sram_en  in  1  data request valid (held while stalled)
- data_sram_wen  in  4  data byte write enables; nonzero means write
- data_sram_addr  in  32  data address
- data_sram_wdata  in  32  data write data
- data_sram_rdata  out  32  data read data, held
- stallreq  out  1  core stall request
- mem_req  out  1  memory request valid
- mem_wen  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response valid; returned for reads and writes
- mem_rdata  in  32  response data

## Operation
- FSM states: IDLE, REQ (mem_req=1, waiting for mem_gnt), RESP (waiting for mem_rvalid).
- In IDLE, when a port's en=1 and resp_done=0, the bridge captures addr/wen/wdata into an owner-tagged request register and moves to REQ.
  - If both ports request together, data is issued first and inst is latched into a one-entry pending buffer.
- REQ→RESP on mem_gnt=1. RESP→REQ on mem_rvalid when the pending buffer is valid; otherwise RESP→IDLE.
- On mem_rvalid with a read, mem_rdata is stored into the owner's rdata register. Writes leave rdata unchanged.
- When the last outstanding response of a batch arrives, resp_done is set for exactly one cycle.
- stallreq = (inst_sram_en | data_sram_en) & ~resp_done (combinational).
- While resp_done=1, no capture occurs. The core advances at that edge, and any new en is captured from the next cycle.
- Only one memory transaction is outstanding at a time. mem_* outputs are driven only from registers.
- Reset (any time, including mid-transaction): state=IDLE, mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0, pending=0, resp_done=0, both rdata=0, stallreq follows en (1 if en asserted).
  - The memory side is reset together with the bridge, so no stale rvalid is expected.
- mem_rvalid in IDLE or REQ is ignored.

## Timing
- Single read, zero-wait memory (gnt in the first REQ cycle, rvalid one cycle later):
  - cycle 0: en, capture
  - cycle 1: mem_req, gnt
  - cycle 2: rvalid
  - cycle 3: rdata valid, resp_done=1, stallreq=0
  - Minimum request-to-release latency is therefore 3 cycles.
- Dual request adds 2 cycles: data response, then inst REQ/RESP. resp_done rises only after the inst response.
- gnt may be delayed arbitrarily; mem_req and payload stay stable until gnt.
- rdata registers change only on mem_rvalid for their owner, or on reset.

## Structure
- Shared package: FSM state enum (IDLE/REQ/RESP), owner tag constants (OWN_INST, OWN_DATA), request record typedef {owner, wen, addr, wdata}.
- One natural sub-module: sram_req_buf, the one-entry pending request register with valid flag.

## Test plan
- Inst read 0xBFC0_0000, mem returns 0x2408_0001 (gnt immediate, rvalid +1):
  - inst_sram_rdata=0x2408_0001 at cycle 3
  - stallreq high cycles 0–2, low at cycle 3
- Simultaneous data write (wen=4'hF, addr 0x8000_0010, wdata 0xDEAD_BEEF) and inst read 0xBFC0_0004:
  - mem sees the write first, then the read
  - data_sram_rdata unchanged
  - stallreq released only after the inst rvalid
- gnt delayed 4 cycles:
  - mem_req/addr/wen/wdata stable throughout
  - single transaction issued
  - latency = 3+4 cycles
- Data read 0x8000_0020 returns 0x1234_5678, followed by held inst_en across resp_done:
  - no duplicate issue in the resp_done cycle
  - next capture the cycle after
- Async rst asserted while in RESP:
  - outputs reset immediately (mem_req=0, rdata=0, state IDLE)
  - after release, a fresh read completes normally
- Spurious mem_rvalid in IDLE with mem_rdata 0xFFFF_FFFF → both rdata registers unchanged.
